// File: rtl/hdmi_tmds_channel_encoder.sv
// ============================================================================
// hdmi_tmds_channel_encoder : two-stage HDMI TMDS lane encoder
//   (video 8b/10b, control, guard bands, TERC4). Rev 1.0
// ============================================================================
`default_nettype none

module hdmi_tmds_channel_encoder #(
   parameter int CHANNEL = 0,
   parameter int CNT_W   = 6
) (
   input  logic                    I_rgb_clk,
   input  logic                    I_rst_n,
   input  logic [2:0]              I_mode,
   input  logic [7:0]              I_data,
   input  logic [1:0]              I_ctrl,
   input  logic [3:0]              I_terc4,
   output logic [9:0]              O_tmds,
   output logic signed [CNT_W-1:0] O_disparity
);

   localparam logic [2:0] c_MODE_CTRL  = 3'd0;
   localparam logic [2:0] c_MODE_VIDEO = 3'd1;
   localparam logic [2:0] c_MODE_VGB   = 3'd2;
   localparam logic [2:0] c_MODE_DATA  = 3'd3;
   localparam logic [2:0] c_MODE_DGB   = 3'd4;

   localparam logic [9:0] c_CTRL_00 = 10'h354;
   localparam logic [9:0] c_CTRL_01 = 10'h0AB;
   localparam logic [9:0] c_CTRL_10 = 10'h154;
   localparam logic [9:0] c_CTRL_11 = 10'h2AB;
   localparam logic [9:0] c_GB_HIGH = 10'h2CC;
   localparam logic [9:0] c_GB_LOW  = 10'h133;

   // Lane indices above 2 are treated as the red lane.
   localparam int         c_LANE      = (CHANNEL > 2) ? 2 : CHANNEL;
   localparam logic [9:0] c_VGB_CODE  = (c_LANE == 1) ? c_GB_LOW : c_GB_HIGH;
   localparam bit         c_DGB_TERC4 = (c_LANE == 0);

   function automatic logic [9:0] f_terc4(input logic [3:0] i_nib);
      case (i_nib)
         4'h0:    return 10'h29C;
         4'h1:    return 10'h263;
         4'h2:    return 10'h2E4;
         4'h3:    return 10'h2E2;
         4'h4:    return 10'h171;
         4'h5:    return 10'h11E;
         4'h6:    return 10'h18E;
         4'h7:    return 10'h13C;
         4'h8:    return 10'h2CC;
         4'h9:    return 10'h139;
         4'hA:    return 10'h19C;
         4'hB:    return 10'h2C6;
         4'hC:    return 10'h28E;
         4'hD:    return 10'h271;
         4'hE:    return 10'h163;
         default: return 10'h2C3;
      endcase
   endfunction

   // ---------------------------------------------------------------- stage 1
   logic [3:0] w_n1d;
   logic       w_use_xnor;
   logic [8:0] w_qm;
   logic [3:0] w_qm_n1;
   logic [2:0] w_mode_s1;

   always_comb begin
      w_n1d = '0;
      for (int i = 0; i < 8; i++) begin
         w_n1d = w_n1d + 4'(I_data[i]);
      end
      w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !I_data[0]);

      w_qm    = '0;
      w_qm[0] = I_data[0];
      for (int i = 1; i < 8; i++) begin
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ I_data[i]) : (w_qm[i-1] ^ I_data[i]);
      end
      w_qm[8] = ~w_use_xnor;

      w_qm_n1 = '0;
      for (int i = 0; i < 8; i++) begin
         w_qm_n1 = w_qm_n1 + 4'(w_qm[i]);
      end

      // Reserved modes collapse to control here so stage 2 sees only 0..4.
      w_mode_s1 = (I_mode > c_MODE_DGB) ? c_MODE_CTRL : I_mode;
   end

   logic [2:0] r_mode;
   logic [1:0] r_ctrl;
   logic [3:0] r_terc4;
   logic [8:0] r_qm;
   logic [3:0] r_n1;
   logic [3:0] r_n0;

   always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_mode  <= c_MODE_CTRL;
         r_ctrl  <= 2'b00;
         r_terc4 <= '0;
         r_qm    <= '0;
         r_n1    <= '0;
         r_n0    <= '0;
      end else begin
         r_mode  <= w_mode_s1;
         r_ctrl  <= I_ctrl;
         r_terc4 <= I_terc4;
         r_qm    <= w_qm;
         r_n1    <= w_qm_n1;
         r_n0    <= 4'd8 - w_qm_n1;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [9:0]              r_tmds;
   logic signed [CNT_W-1:0] r_disp;
   logic [9:0]              w_tmds_nxt;
   logic signed [CNT_W-1:0] w_disp_nxt;
   logic signed [CNT_W-1:0] w_bal;
   logic signed [CNT_W-1:0] w_two_q8;
   logic signed [CNT_W-1:0] w_two_nq8;
   logic                    w_disp_pos;
   logic                    w_disp_neg;

   always_comb begin
      w_bal      = $signed({{(CNT_W-4){1'b0}}, r_n1}) - $signed({{(CNT_W-4){1'b0}}, r_n0});
      w_two_q8   = r_qm[8] ? CNT_W'(2) : '0;
      w_two_nq8  = r_qm[8] ? '0 : CNT_W'(2);
      w_disp_neg = r_disp[CNT_W-1];
      w_disp_pos = !r_disp[CNT_W-1] && (r_disp != '0);

      w_tmds_nxt = c_CTRL_00;
      w_disp_nxt = '0;
      case (r_mode)
         c_MODE_VIDEO: begin
            if ((r_disp == '0) || (r_n1 == r_n0)) begin
               w_tmds_nxt = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
               w_disp_nxt = r_qm[8] ? (r_disp + w_bal) : (r_disp - w_bal);
            end else if ((w_disp_pos && (r_n1 > r_n0)) || (w_disp_neg && (r_n0 > r_n1))) begin
               w_tmds_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
               w_disp_nxt = r_disp + w_two_q8 - w_bal;
            end else begin
               w_tmds_nxt = {1'b0, r_qm[8], r_qm[7:0]};
               w_disp_nxt = r_disp - w_two_nq8 + w_bal;
            end
         end
         c_MODE_CTRL: begin
            case (r_ctrl)
               2'b00:   w_tmds_nxt = c_CTRL_00;
               2'b01:   w_tmds_nxt = c_CTRL_01;
               2'b10:   w_tmds_nxt = c_CTRL_10;
               default: w_tmds_nxt = c_CTRL_11;
            endcase
         end
         c_MODE_VGB:  w_tmds_nxt = c_VGB_CODE;
         c_MODE_DATA: w_tmds_nxt = f_terc4(r_terc4);
         c_MODE_DGB:  w_tmds_nxt = c_DGB_TERC4 ? f_terc4(r_terc4) : c_GB_LOW;
         default:     w_tmds_nxt = c_CTRL_00;
      endcase
   end

   always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_tmds <= c_CTRL_00;
         r_disp <= '0;
      end else begin
         r_tmds <= w_tmds_nxt;
         r_disp <= w_disp_nxt;
      end
   end

   assign O_tmds      = r_tmds;
   assign O_disparity = r_disp;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_tmds_channel_encoder.sv
// Testbench for hdmi_tmds_channel_encoder: table vectors, reset sequences and a
// random mode mix, all checked through a 2-deep expected-result queue.
`default_nettype none

module tb_hdmi_tmds_channel_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] mode;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic [3:0] terc4;
   logic [9:0] tmds [3];
   logic [5:0] disp [3];

   hdmi_tmds_channel_encoder #(.CHANNEL(0), .CNT_W(6)) u_ch0 (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_mode(mode), .I_data(data), .I_ctrl(ctrl),
      .I_terc4(terc4), .O_tmds(tmds[0]), .O_disparity(disp[0]));
   hdmi_tmds_channel_encoder #(.CHANNEL(1), .CNT_W(6)) u_ch1 (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_mode(mode), .I_data(data), .I_ctrl(ctrl),
      .I_terc4(terc4), .O_tmds(tmds[1]), .O_disparity(disp[1]));
   hdmi_tmds_channel_encoder #(.CHANNEL(2), .CNT_W(6)) u_ch2 (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_mode(mode), .I_data(data), .I_ctrl(ctrl),
      .I_terc4(terc4), .O_tmds(tmds[2]), .O_disparity(disp[2]));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0][9:0] tmds;
      int              disp;
      bit              video;
      int              tag;
   } exp_t;

   typedef struct {
      logic [2:0]      mode;
      logic [7:0]      data;
      logic [1:0]      ctrl;
      logic [3:0]      terc4;
      logic [2:0][9:0] tmds;
      int              disp;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   m_disp = 0;
   int   prev_disp = 0;

   logic [9:0] terc_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E,
                                 10'h18E, 10'h13C, 10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                 10'h28E, 10'h271, 10'h163, 10'h2C3};
   logic [9:0] ctl_tab [4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   task automatic chk_h(input string nm, input int tag, input int c, input logic [9:0] got,
                        input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s tag=%0d ch=%0d got=%h exp=%h", nm, tag, c, got, exp);
      end
   endtask

   task automatic chk_d(input string nm, input int tag, input int c, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s tag=%0d ch=%0d got=%0d exp=%0d", nm, tag, c, got, exp);
      end
   endtask

   // Reference encoder; keeps its own running disparity in m_disp.
   task automatic model(input logic [2:0] md, input logic [7:0] d, input logic [1:0] ct,
                        input logic [3:0] t, output exp_t e);
      logic [8:0] qm;
      logic [9:0] v;
      int         n1, n0;
      bit         x;
      e.video = (md == 3'd1);
      e.tag   = 0;
      v       = '0;
      qm      = '0;
      if (md == 3'd1) begin
         x     = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
         qm[0] = d[0];
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ x;
         qm[8] = !x;
         n1 = $countones(qm[7:0]);
         n0 = 8 - n1;
         if (m_disp == 0 || n1 == n0) begin
            if (qm[8]) begin v = {2'b01, qm[7:0]};  m_disp += n1 - n0; end
            else       begin v = {2'b10, ~qm[7:0]}; m_disp += n0 - n1; end
         end else if ((m_disp > 0 && n1 > n0) || (m_disp < 0 && n0 > n1)) begin
            v = {1'b1, qm[8], ~qm[7:0]};
            m_disp += 2 * int'(qm[8]) + n0 - n1;
         end else begin
            v = {1'b0, qm[8], qm[7:0]};
            m_disp += -2 * (1 - int'(qm[8])) + n1 - n0;
         end
      end else begin
         m_disp = 0;
      end
      for (int c = 0; c < 3; c++) begin
         case (md)
            3'd1:    e.tmds[c] = v;
            3'd2:    e.tmds[c] = (c == 1) ? 10'h133 : 10'h2CC;
            3'd3:    e.tmds[c] = terc_tab[t];
            3'd4:    e.tmds[c] = (c == 0) ? terc_tab[t] : 10'h133;
            default: e.tmds[c] = ctl_tab[ct];
         endcase
      end
      e.disp = m_disp;
   endtask

   // One symbol per negedge; the entry pushed two steps earlier is now on O_tmds.
   task automatic step_exp(input logic [2:0] md, input logic [7:0] d, input logic [1:0] ct,
                           input logic [3:0] t, input exp_t e);
      exp_t a;
      @(negedge clk);
      if (sbq.size() >= 2) begin
         a = sbq.pop_front();
         for (int c = 0; c < 3; c++) begin
            chk_h("tmds", a.tag, c, tmds[c], a.tmds[c]);
            chk_d("disp", a.tag, c, int'($signed(disp[c])), a.disp);
            if (a.video)
               chk_d("dcbal", a.tag, c, int'($signed(disp[c])) - prev_disp,
                     2 * $countones(tmds[c]) - 10);
         end
         prev_disp = a.disp;
      end
      mode  = md;
      data  = d;
      ctrl  = ct;
      terc4 = t;
      sbq.push_back(e);
   endtask

   task automatic step(input logic [2:0] md, input logic [7:0] d, input logic [1:0] ct,
                       input logic [3:0] t, input int tag);
      exp_t e;
      model(md, d, ct, t, e);
      e.tag = tag;
      step_exp(md, d, ct, t, e);
   endtask

   task automatic after_release();
      exp_t r;
      r.tmds  = {3{10'h354}};
      r.disp  = 0;
      r.video = 1'b0;
      r.tag   = -1;
      sbq.delete();
      sbq.push_back(r);
      sbq.push_back(r);
      m_disp    = 0;
      prev_disp = 0;
   endtask

   task automatic chk_reset_now(input int tag);
      for (int c = 0; c < 3; c++) begin
         chk_h("rst_tmds", tag, c, tmds[c], 10'h354);
         chk_d("rst_disp", tag, c, int'($signed(disp[c])), 0);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] md, input logic [7:0] d, input logic [1:0] ct,
                               input logic [3:0] t, input logic [9:0] t0, input logic [9:0] t1,
                               input logic [9:0] t2, input int dp);
      vec_t v;
      v.mode = md; v.data = d; v.ctrl = ct; v.terc4 = t;
      v.tmds[0] = t0; v.tmds[1] = t1; v.tmds[2] = t2;
      v.disp = dp;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      vec_t v;
      logic [2:0] md;
      int r;

      rst_n = 1'b0; mode = '0; data = '0; ctrl = '0; terc4 = '0;

      vecs.push_back(mk(3'd0, 8'h00, 2'd0, 4'h0, 10'h354, 10'h354, 10'h354, 0));
      vecs.push_back(mk(3'd0, 8'h00, 2'd1, 4'h0, 10'h0AB, 10'h0AB, 10'h0AB, 0));
      vecs.push_back(mk(3'd0, 8'h00, 2'd2, 4'h0, 10'h154, 10'h154, 10'h154, 0));
      vecs.push_back(mk(3'd0, 8'h00, 2'd3, 4'h0, 10'h2AB, 10'h2AB, 10'h2AB, 0));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h100, 10'h100, 10'h100, -8));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h3FF, 10'h3FF, 10'h3FF, 2));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h100, 10'h100, 10'h100, -6));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h3FF, 10'h3FF, 10'h3FF, 4));
      vecs.push_back(mk(3'd0, 8'h55, 2'd0, 4'h7, 10'h354, 10'h354, 10'h354, 0));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h100, 10'h100, 10'h100, -8));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h3FF, 10'h3FF, 10'h3FF, 2));
      vecs.push_back(mk(3'd2, 8'hA5, 2'd3, 4'h5, 10'h2CC, 10'h133, 10'h2CC, 0));
      vecs.push_back(mk(3'd1, 8'h00, 2'd0, 4'h0, 10'h100, 10'h100, 10'h100, -8));
      for (int t = 0; t < 16; t++)
         vecs.push_back(mk(3'd3, 8'h00, 2'd0, 4'(t), terc_tab[t], terc_tab[t], terc_tab[t], 0));
      vecs.push_back(mk(3'd4, 8'h00, 2'd0, 4'hC, 10'h28E, 10'h133, 10'h133, 0));
      vecs.push_back(mk(3'd4, 8'h00, 2'd0, 4'h3, 10'h2E2, 10'h133, 10'h133, 0));
      vecs.push_back(mk(3'd5, 8'h00, 2'd1, 4'h0, 10'h0AB, 10'h0AB, 10'h0AB, 0));
      vecs.push_back(mk(3'd6, 8'h00, 2'd2, 4'h0, 10'h154, 10'h154, 10'h154, 0));
      vecs.push_back(mk(3'd7, 8'h00, 2'd3, 4'h0, 10'h2AB, 10'h2AB, 10'h2AB, 0));
      vecs.push_back(mk(3'd1, 8'hFF, 2'd0, 4'h0, 10'h200, 10'h200, 10'h200, -8));
      vecs.push_back(mk(3'd1, 8'hFF, 2'd0, 4'h0, 10'h0FF, 10'h0FF, 10'h0FF, -2));
      vecs.push_back(mk(3'd1, 8'h1E, 2'd0, 4'h0, 10'h25F, 10'h25F, 10'h25F, 2));

      #12;
      chk_reset_now(-2);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      after_release();

      foreach (vecs[i]) begin
         v = vecs[i];
         model(v.mode, v.data, v.ctrl, v.terc4, e);
         e.tmds = v.tmds;
         e.disp = v.disp;
         e.tag  = i;
         step_exp(v.mode, v.data, v.ctrl, v.terc4, e);
      end

      // Reset asserted between clock edges while video symbols are in flight.
      for (int i = 0; i < 3; i++) step(3'd1, 8'h00, 2'd0, 4'h0, 200 + i);
      @(posedge clk);
      #2 rst_n = 1'b0;
      mode = '0; data = '0; ctrl = '0; terc4 = '0;
      #1;
      chk_reset_now(-3);
      @(negedge clk);
      chk_reset_now(-4);
      @(negedge clk);
      rst_n = 1'b1;
      after_release();
      for (int i = 0; i < 3; i++) step(3'd1, 8'h00, 2'd0, 4'h0, 300 + i);

      for (int i = 0; i < 10000; i++) begin
         r  = int'($urandom_range(0, 11));
         md = (r < 4) ? 3'd1 : 3'(r - 4);
         step(md, 8'($urandom), 2'($urandom), 4'($urandom), 1000 + i);
      end
      step(3'd0, 8'h00, 2'd0, 4'h0, 90000);
      step(3'd0, 8'h00, 2'd0, 4'h0, 90001);
      step(3'd0, 8'h00, 2'd0, 4'h0, 90002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hdmi_tmds_channel_encoder.md
Name: hdmi_tmds_channel_encoder

Overview:
- Parametrised, pipelined TMDS channel encoder for the HDMI transmit path; next generation of the DVI-only per-channel encoder.
- Adds HDMI period modes on top of DVI video/control encoding: video guard band, data-island guard band, and TERC4 data-island encoding.
- Three instances (blue/green/red, selected by CHANNEL) sit between the video/packet scheduler and the OSER10 10:1 serializers.
- Runs entirely in the pixel clock domain.

Parameters:
- CHANNEL, 0: lane index (0 = blue, 1 = green, 2 = red). Selects the guard-band codes. Values >2 behave as 2.
- CNT_W, 6: width of the signed running-disparity counter. Minimum 5.

Ports:
- I_rgb_clk  in  1  pixel clock; all state updates on the rising edge.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_mode  in  3  period select: 0 control, 1 video, 2 video guard band, 3 data island, 4 data-island guard band; 5-7 are treated as 0.
- I_data  in  8  pixel component; used in mode 1.
- I_ctrl  in  2  {C1,C0} control bits; used in mode 0.
- I_terc4  in  4  TERC4 nibble; used in mode 3, and in mode 4 when CHANNEL = 0.
- O_tmds  out  10  encoded symbol; bit 0 is transmitted first (maps to OSER10 D0).
- O_disparity  out  CNT_W  signed running disparity after the current output symbol (debug/verification).

Behaviour:
- Reset (async assert, sync release):
  - O_tmds = 10'b1101010100 (control code for 00).
  - O_disparity = 0.
  - All pipeline registers cleared, with the stored mode forced to 0 and ctrl to 00.
- Latency: exactly 2 clocks from the input sample to O_tmds. One input is accepted every clock; there is no stall or backpressure.
- Stage 1 (registered): latch mode, ctrl, terc4. Compute:
  - n1d = popcount(I_data).
  - q_m[8:0] using XNOR if (n1d > 4) or (n1d == 4 and I_data[0] == 0); otherwise XOR.
  - q_m[0] = d[0]; q_m[i] = q_m[i-1] XOR/XNOR d[i]; q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m, plus n1 and n0 of q_m[7:0].
- Stage 2, mode 1 (video), using cnt = current disparity:
  - If cnt == 0 or n1 == n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1 - n0) : (n0 - n1).
  - Else if (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0 - n1).
  - Else:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (n1 - n0).
  - Arithmetic is signed CNT_W bits. CNT_W >= 5 guarantees no overflow.
- Stage 2, every non-video mode: cnt is forced to 0 in the same cycle.
  - Mode 0: ctrl 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
  - Mode 2: CHANNEL 0 or 2 -> 1011001100; CHANNEL 1 -> 0100110011.
  - Mode 3: TERC4(terc4), table 0..F:
    - 0-3: 1010011100, 1001100011, 1011100100, 1011100010
    - 4-7: 0101110001, 0100011110, 0110001110, 0100111100
    - 8-B: 1011001100, 0100111001, 0110011100, 1011000110
    - C-F: 1010001110, 1001110001, 0101100011, 1011000011
  - Mode 4: CHANNEL 0 -> TERC4(terc4), with the caller supplying {1,1,VS,HS}; CHANNEL 1 or 2 -> 0100110011.
- Mode transitions take effect on a per-symbol basis with no gap.
  - The first video symbol after any non-video symbol starts from cnt = 0.
  - Changing I_data, ctrl or terc4 while the mode is non-video has no effect on disparity.
- Reset mid-frame: outputs and disparity return to their reset values immediately. Symbols already in flight are discarded.
- O_disparity updates together with O_tmds (same register stage).

Test Plan:
- Reset asserted during a video stream -> O_tmds = 0x354 (1101010100) and O_disparity = 0 asynchronously. After release, stays 0x354 until the first input reaches stage 2.
- Mode 0, ctrl = 00, 01, 10, 11 on consecutive clocks -> two clocks later O_tmds = 0x354, 0x0AB, 0x154, 0x2AB; O_disparity = 0 throughout.
- Mode 1, I_data = 0x00 for 4 clocks after control -> O_tmds = 0x100, 0x3FF, 0x100, 0x3FF; O_disparity = -8, 2, -6, 4.
- Mode 1 run interrupted by one mode-0 symbol, then 0x00 again -> the disparity resets to 0 on the control symbol; the next video symbol is 0x100 with disparity -8.
- Modes 2, 3 (terc4 = 0..F) and 4 on CHANNEL = 0 and CHANNEL = 1 instances:
  - Exact table codes appear after 2 clocks.
  - Mode 4 on CHANNEL 1 gives 0x133 regardless of terc4.
- Random 10k-symbol mix of all modes, including I_mode 5-7 -> O_tmds matches a reference model cycle-for-cycle. Each video symbol's DC balance matches O_disparity, and modes 5-7 produce control codes.
